// File: rtl/sim_pcie_host_completer.sv
// Host memory model behind the simulated PCIe link: absorbs MWr/MRd TX TLPs, answers each MRd with one CplD.
// Latency: MWr data lands on its accepting edge; CplD DW0 is valid on the edge that accepts the MRd tlast beat.
// Backpressure: s_axis_tready is held low for the whole completion; completion beats advance only on m_axis_tready.
module sim_pcie_host_completer #(
    parameter int          MEM_DEPTH_LOG2 = 10,
    parameter logic [15:0] COMPLETER_ID   = 16'h0000
) (
    input  logic        sys_clk_p,
    input  logic        sys_reset,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] o_mwr_count,
    output logic [31:0] o_mrd_count,
    output logic        o_err
);

    localparam int AW    = MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        H0, H1, H2, H3, WDATA, DRAIN, C0, C1, C2, CDATA
    } state_t;

    state_t state, state_nxt;

    // Host memory, word addressed, intentionally left unreset
    logic [31:0] mem [DEPTH];

    // Captured header fields
    logic [1:0]    fmt_q, fmt_n;
    logic [4:0]    typ_q, typ_n;
    logic [9:0]    len_q, len_n;
    logic [15:0]   reqid_q, reqid_n;
    logic [7:0]    tag_q, tag_n;
    logic [3:0]    lbe_q, lbe_n;
    logic [3:0]    fbe_q, fbe_n;
    logic [AW-1:0] idx_q, idx_n;
    logic [4:0]    alo_q, alo_n;

    // Payload / completion word counter and "MRd waiting behind a drain" flag
    logic [10:0]   cnt_q, cnt_n;
    logic          rd_pend_q, rd_pend_n;

    // Next values of the registered outputs
    logic          s_rdy_n;
    logic [31:0]   m_dat_n;
    logic          m_last_n;
    logic          m_vld_n;
    logic [31:0]   mwr_n, mrd_n;
    logic          err_n;

    logic          s_hs, m_hs;
    logic          is_mwr, is_mrd, hdr_last, cnt_last;
    logic [10:0]   len_dw;
    logic [10:0]   rd_off;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [3:0]    wr_be;
    logic          mem_we;

    // Byte lanes are always treated as full DWs
    logic          unused_keep;
    assign unused_keep = ^s_axis_tkeep;

    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign m_hs     = m_axis_tvalid && m_axis_tready;
    assign is_mwr   = fmt_q[1] && (typ_q == 5'b00000);
    assign is_mrd   = !fmt_q[1] && (typ_q == 5'b00000);
    // H2 closes a 3DW header, H3 a 4DW header
    assign hdr_last = (state == H3) || ((state == H2) && !fmt_q[0]);
    // A length field of zero encodes 1024 DWs
    assign len_dw   = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
    assign cnt_last = (cnt_q == len_dw - 11'd1);

    // Addresses wrap modulo the memory depth by truncation
    assign wr_addr  = idx_q + AW'(cnt_q);
    assign rd_off   = (state == C2) ? 11'd0 : cnt_q + 11'd1;
    assign rd_addr  = idx_q + AW'(rd_off);
    assign wr_be    = (cnt_q == 11'd0) ? fbe_q : (cnt_last ? lbe_q : 4'hF);
    assign mem_we   = (state == WDATA) && s_hs;

    // State register
    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            state <= H0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: header walk, payload/drain, then the four completion phases
    always_comb begin
        state_nxt = state;
        case (state)
            H0: if (s_hs) state_nxt = s_axis_tlast ? H0 : H1;
            H1: if (s_hs) state_nxt = s_axis_tlast ? H0 : H2;
            H2, H3: begin
                if (s_hs) begin
                    if (!hdr_last)   state_nxt = s_axis_tlast ? H0 : H3;
                    else if (is_mwr) state_nxt = s_axis_tlast ? H0 : WDATA;
                    else if (is_mrd) state_nxt = s_axis_tlast ? C0 : DRAIN;
                    else             state_nxt = s_axis_tlast ? H0 : DRAIN;
                end
            end
            WDATA: if (s_hs) state_nxt = s_axis_tlast ? H0 : (cnt_last ? DRAIN : WDATA);
            DRAIN: if (s_hs && s_axis_tlast) state_nxt = rd_pend_q ? C0 : H0;
            C0:    if (m_hs) state_nxt = C1;
            C1:    if (m_hs) state_nxt = C2;
            C2:    if (m_hs) state_nxt = CDATA;
            CDATA: if (m_hs && cnt_last) state_nxt = H0;
            default: state_nxt = H0;
        endcase
    end

    // Output/datapath decode: header capture, error flagging, counters and completion beat selection
    always_comb begin
        fmt_n     = fmt_q;
        typ_n     = typ_q;
        len_n     = len_q;
        reqid_n   = reqid_q;
        tag_n     = tag_q;
        lbe_n     = lbe_q;
        fbe_n     = fbe_q;
        idx_n     = idx_q;
        alo_n     = alo_q;
        cnt_n     = cnt_q;
        rd_pend_n = rd_pend_q;
        m_dat_n   = m_axis_tdata;
        m_last_n  = m_axis_tlast;
        mwr_n     = o_mwr_count;
        mrd_n     = o_mrd_count;
        err_n     = o_err;
        // Ready and valid follow the state being entered, so both flip on the same edge
        s_rdy_n   = !(state_nxt inside {C0, C1, C2, CDATA});
        m_vld_n   = state_nxt inside {C0, C1, C2, CDATA};

        case (state)
            H0: begin
                if (s_hs) begin
                    fmt_n     = s_axis_tdata[30:29];
                    typ_n     = s_axis_tdata[28:24];
                    len_n     = s_axis_tdata[9:0];
                    rd_pend_n = 1'b0;
                    if (s_axis_tlast) err_n = 1'b1;
                end
            end
            H1: begin
                if (s_hs) begin
                    reqid_n = s_axis_tdata[31:16];
                    tag_n   = s_axis_tdata[15:8];
                    lbe_n   = s_axis_tdata[7:4];
                    fbe_n   = s_axis_tdata[3:0];
                    if (s_axis_tlast) err_n = 1'b1;
                end
            end
            H2, H3: begin
                if (s_hs) begin
                    // The upper address DW of a 4DW header is not stored
                    if (hdr_last) begin
                        idx_n = s_axis_tdata[AW+1:2];
                        alo_n = s_axis_tdata[6:2];
                    end
                    cnt_n = 11'd0;
                    if (!hdr_last) begin
                        if (s_axis_tlast) err_n = 1'b1;
                    end else if (is_mwr) begin
                        if (s_axis_tlast) err_n = 1'b1;
                    end else if (is_mrd) begin
                        if (!s_axis_tlast) begin
                            err_n     = 1'b1;
                            rd_pend_n = 1'b1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (s_hs) begin
                    cnt_n = cnt_q + 11'd1;
                    if (cnt_last) begin
                        mwr_n = o_mwr_count + 32'd1;
                        if (!s_axis_tlast) err_n = 1'b1;
                    end else if (s_axis_tlast) begin
                        err_n = 1'b1;
                    end
                end
            end
            C0: begin
                if (m_hs) m_dat_n = {COMPLETER_ID, 3'b000, 1'b0, len_q, 2'b00};
            end
            C1: begin
                if (m_hs) m_dat_n = {reqid_q, tag_q, 1'b0, alo_q, 2'b00};
            end
            C2: begin
                if (m_hs) begin
                    cnt_n    = 11'd0;
                    m_dat_n  = mem[rd_addr];
                    m_last_n = (len_dw == 11'd1);
                end
            end
            CDATA: begin
                if (m_hs) begin
                    if (cnt_last) begin
                        m_dat_n  = '0;
                        m_last_n = 1'b0;
                        mrd_n    = o_mrd_count + 32'd1;
                    end else begin
                        cnt_n    = cnt_q + 11'd1;
                        m_dat_n  = mem[rd_addr];
                        m_last_n = (cnt_q + 11'd2 == len_dw);
                    end
                end
            end
            default: ;
        endcase

        // CplD DW0 is presented on the edge that enters C0
        if ((state_nxt == C0) && (state != C0)) begin
            m_dat_n  = 32'h4A000000 | {22'd0, len_q};
            m_last_n = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            fmt_q         <= '0;
            typ_q         <= '0;
            len_q         <= '0;
            reqid_q       <= '0;
            tag_q         <= '0;
            lbe_q         <= '0;
            fbe_q         <= '0;
            idx_q         <= '0;
            alo_q         <= '0;
            cnt_q         <= '0;
            rd_pend_q     <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            o_mwr_count   <= '0;
            o_mrd_count   <= '0;
            o_err         <= 1'b0;
        end else begin
            fmt_q         <= fmt_n;
            typ_q         <= typ_n;
            len_q         <= len_n;
            reqid_q       <= reqid_n;
            tag_q         <= tag_n;
            lbe_q         <= lbe_n;
            fbe_q         <= fbe_n;
            idx_q         <= idx_n;
            alo_q         <= alo_n;
            cnt_q         <= cnt_n;
            rd_pend_q     <= rd_pend_n;
            s_axis_tready <= s_rdy_n;
            m_axis_tdata  <= m_dat_n;
            m_axis_tlast  <= m_last_n;
            m_axis_tvalid <= m_vld_n;
            o_mwr_count   <= mwr_n;
            o_mrd_count   <= mrd_n;
            o_err         <= err_n;
        end
    end

    // Byte-enabled memory write on the accepting edge of each payload beat
    always_ff @(posedge sys_clk_p) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= s_axis_tdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sim_pcie_host_completer.sv
// Bench for the host completer: random/directed TLPs against a queue-based host memory model.
module tb_sim_pcie_host_completer;

    localparam int DEPTH = 1024;

    logic        sys_clk_p = 1'b0;
    logic        sys_reset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] o_mwr_count;
    logic [31:0] o_mrd_count;
    logic        o_err;

    sim_pcie_host_completer dut (
        .sys_clk_p     (sys_clk_p),
        .sys_reset     (sys_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .o_mwr_count   (o_mwr_count),
        .o_mrd_count   (o_mrd_count),
        .o_err         (o_err)
    );

    always #5 sys_clk_p = ~sys_clk_p;

    int n_assert = 0;
    int n_fail   = 0;
    bit stuck    = 0;

    // Reference model state
    logic [31:0] mm [DEPTH];
    int          mwr_exp = 0;
    int          mrd_exp = 0;
    bit          err_exp = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_exp[$];
    logic [31:0] wr_q[$];

    task automatic send_tlp(input bit gaps);
        int wait_cyc;
        if (stuck) return;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge sys_clk_p);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(negedge sys_clk_p);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_q[i];
            s_axis_tlast  = (i == tx_q.size() - 1);
            wait_cyc = 0;
            while (s_axis_tready !== 1'b1 && wait_cyc < 200) begin
                @(negedge sys_clk_p);
                wait_cyc++;
            end
            if (wait_cyc >= 200) begin
                n_assert++;
                n_fail++;
                $display("FAIL send_timeout: beat %0d not accepted, s_axis_tready=%b required 1", i, s_axis_tready);
                stuck = 1;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(posedge sys_clk_p);
        end
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic recv_cpl(input int stall_beat, input int stall_cycles, input bit rnd);
        int n, got, cyc, stall_left;
        bit holding, rdy;
        logic [31:0] held;
        n = rx_exp.size();
        got = 0;
        cyc = 0;
        stall_left = stall_cycles;
        holding = 0;
        held = '0;
        @(negedge sys_clk_p);
        n_assert++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL cpl_start: m_axis_tvalid=%b required 1 right after MRd tlast", m_axis_tvalid);
        end
        while (got < n && cyc < 4 * n + 100) begin
            n_assert++;
            if (s_axis_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL cpl_s_tready: s_axis_tready=%b required 0 during completion", s_axis_tready);
            end
            if (holding) begin
                n_assert++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin
                    n_fail++;
                    $display("FAIL cpl_hold: beat %0d tvalid=%b tdata=%h required 1/%h", got, m_axis_tvalid, m_axis_tdata, held);
                end
            end
            if (got == stall_beat && stall_left > 0) begin
                rdy = 0;
                stall_left--;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1;
            end
            m_axis_tready = rdy;
            if (m_axis_tvalid && rdy) begin
                n_assert++;
                if (m_axis_tdata !== rx_exp[got] || m_axis_tlast !== (got == n - 1)) begin
                    n_fail++;
                    $display("FAIL cpl_beat: beat %0d data=%h last=%b required %h/%b",
                             got, m_axis_tdata, m_axis_tlast, rx_exp[got], (got == n - 1));
                end
                got++;
                holding = 0;
            end else begin
                holding = m_axis_tvalid;
                held    = m_axis_tdata;
            end
            @(negedge sys_clk_p);
            cyc++;
        end
        m_axis_tready = 1'b0;
        n_assert++;
        if (got != n) begin
            n_fail++;
            $display("FAIL cpl_timeout: %0d beats received, required %0d", got, n);
        end
        n_assert++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL cpl_end: tvalid=%b s_tready=%b required 0/1 after last beat", m_axis_tvalid, s_axis_tready);
        end
    endtask

    // Memory write: payload from wr_q; extra appends junk beats, short_by ends the TLP early
    task automatic do_mwr(input logic [31:0] addr, input logic [9:0] len, input bit four,
                          input logic [3:0] fbe, input logic [3:0] lbe,
                          input int extra, input int short_by, input bit gaps);
        int n, sent;
        int unsigned ix;
        logic [31:0] w;
        logic [3:0] be;
        n = (len == 10'd0) ? 1024 : int'(len);
        sent = n + extra - short_by;
        tx_q = {};
        tx_q.push_back({1'b0, 1'b1, four, 5'b00000, 14'd0, len});
        tx_q.push_back({16'h0000, 8'h00, lbe, fbe});
        if (four) tx_q.push_back($urandom());
        tx_q.push_back(addr);
        for (int i = 0; i < sent; i++) begin
            w = (i < n) ? wr_q[i] : $urandom();
            tx_q.push_back(w);
            if (i < n) begin
                be = (i == 0) ? fbe : ((i == n - 1) ? lbe : 4'hF);
                ix = ((addr >> 2) + i) % DEPTH;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mm[ix][8*b +: 8] = w[8*b +: 8];
                end
            end
        end
        if (extra > 0 || short_by > 0) err_exp = 1;
        if (short_by == 0) mwr_exp++;
        send_tlp(gaps);
        n_assert++;
        if (o_mwr_count !== 32'(mwr_exp) || o_err !== err_exp) begin
            n_fail++;
            $display("FAIL mwr_status: mwr_count=%0d err=%b required %0d/%b", o_mwr_count, o_err, mwr_exp, err_exp);
        end
    endtask

    // Memory read; keep_exp means the caller already filled rx_exp with literal beats
    task automatic do_mrd(input logic [31:0] addr, input logic [9:0] len, input bit four,
                          input logic [15:0] reqid, input logic [7:0] tag, input int extra,
                          input bit keep_exp, input int stall_beat, input int stall_cycles, input bit rnd);
        int n;
        int bc;
        logic [31:0] addr_byte;
        n = (len == 10'd0) ? 1024 : int'(len);
        tx_q = {};
        tx_q.push_back({1'b0, 1'b0, four, 5'b00000, 14'd0, len});
        tx_q.push_back({reqid, tag, 8'hFF});
        if (four) tx_q.push_back($urandom());
        tx_q.push_back(addr);
        for (int i = 0; i < extra; i++) tx_q.push_back($urandom());
        if (!keep_exp) begin
            bc = (n * 4) % 4096;
            addr_byte = addr & 32'h7C;
            rx_exp = {};
            rx_exp.push_back(32'h4A000000 + 32'(len));
            rx_exp.push_back(32'(bc));
            rx_exp.push_back({reqid, tag, addr_byte[7:0]});
            for (int i = 0; i < n; i++) rx_exp.push_back(mm[((addr >> 2) + i) % DEPTH]);
        end
        if (extra > 0) err_exp = 1;
        mrd_exp++;
        send_tlp(rnd);
        if (stuck) return;
        recv_cpl(stall_beat, stall_cycles, rnd);
        n_assert++;
        if (o_mrd_count !== 32'(mrd_exp) || o_err !== err_exp) begin
            n_fail++;
            $display("FAIL mrd_status: mrd_count=%0d err=%b required %0d/%b", o_mrd_count, o_err, mrd_exp, err_exp);
        end
    endtask

    task automatic test_reset;
        sys_reset = 1'b1;
        repeat (3) @(negedge sys_clk_p);
        n_assert++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_axis: tready=%b tvalid=%b tlast=%b tdata=%h required 0/0/0/0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        n_assert++;
        if (o_mwr_count !== 32'd0 || o_mrd_count !== 32'd0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: mwr=%0d mrd=%0d err=%b required 0/0/0", o_mwr_count, o_mrd_count, o_err);
        end
        sys_reset = 1'b0;
        #1;
        n_assert++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: s_axis_tready=%b required 0 before first edge", s_axis_tready);
        end
        @(negedge sys_clk_p);
        n_assert++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: s_axis_tready=%b required 1 one edge after release", s_axis_tready);
        end
    endtask

    task automatic test_round_trip;
        wr_q = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        do_mwr(32'h10, 10'd2, 1'b0, 4'hF, 4'hF, 0, 0, 1'b0);
        rx_exp = '{32'h4A000002, 32'h00000008, 32'h01000510, 32'hA5A5A5A5, 32'h5A5A5A5A};
        do_mrd(32'h10, 10'd2, 1'b0, 16'h0100, 8'h05, 0, 1'b1, -1, 0, 1'b0);
        n_assert++;
        if (o_mwr_count !== 32'd1 || o_mrd_count !== 32'd1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL round_trip_counts: mwr=%0d mrd=%0d err=%b required 1/1/0", o_mwr_count, o_mrd_count, o_err);
        end
    endtask

    task automatic test_byte_enables;
        wr_q = '{32'hFFFFFFFF};
        do_mwr(32'h40, 10'd1, 1'b0, 4'hF, 4'h0, 0, 0, 1'b0);
        wr_q = '{32'h11223344};
        do_mwr(32'h40, 10'd1, 1'b0, 4'h3, 4'h0, 0, 0, 1'b0);
        rx_exp = '{32'h4A000001, 32'h00000004, 32'h00000040, 32'hFFFF3344};
        do_mrd(32'h40, 10'd1, 1'b0, 16'h0000, 8'h00, 0, 1'b1, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        wr_q = {};
        for (int i = 0; i < 4; i++) wr_q.push_back($urandom());
        do_mwr(32'h80, 10'd4, 1'b1, 4'hF, 4'hF, 0, 0, 1'b1);
        do_mrd(32'h80, 10'd4, 1'b0, 16'h1234, 8'h77, 0, 1'b0, 4, 3, 1'b0);
    endtask

    task automatic test_wrap;
        wr_q = '{32'hCAFEF00D, 32'h0BADBEEF};
        do_mwr(32'hFFC, 10'd2, 1'b0, 4'hF, 4'hF, 0, 0, 1'b0);
        rx_exp = '{32'h4A000001, 32'h00000004, 32'h00000000, 32'h0BADBEEF};
        do_mrd(32'h0, 10'd1, 1'b0, 16'h0000, 8'h00, 0, 1'b1, -1, 0, 1'b0);
        do_mrd(32'hFFC, 10'd2, 1'b1, 16'h0042, 8'h99, 0, 1'b0, -1, 0, 1'b1);
        wr_q = {};
        for (int i = 0; i < 1024; i++) wr_q.push_back($urandom());
        do_mwr(32'h0, 10'd0, 1'b1, 4'hF, 4'hF, 0, 0, 1'b1);
        do_mrd(32'h0, 10'd0, 1'b0, 16'hBEEF, 8'h01, 0, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_random;
        logic [9:0] len;
        for (int it = 0; it < 24; it++) begin
            len = 10'($urandom_range(1, 16));
            if ($urandom_range(0, 1) == 0) begin
                wr_q = {};
                for (int i = 0; i < int'(len); i++) wr_q.push_back($urandom());
                do_mwr($urandom(), len, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 0, 0, 1'b1);
            end else begin
                do_mrd($urandom(), len, 1'($urandom_range(0, 1)), 16'($urandom()), 8'($urandom()),
                       0, 1'b0, -1, 0, 1'b1);
            end
        end
    endtask

    task automatic test_malformed;
        wr_q = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        do_mwr(32'h200, 10'd4, 1'b0, 4'hF, 4'hF, 0, 2, 1'b0);
        do_mrd(32'h200, 10'd4, 1'b0, 16'h0007, 8'h08, 0, 1'b0, -1, 0, 1'b0);
        wr_q = '{32'h55667788};
        do_mwr(32'h300, 10'd1, 1'b0, 4'hF, 4'h0, 2, 0, 1'b1);
        do_mrd(32'h300, 10'd1, 1'b1, 16'h0009, 8'h0A, 2, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        tx_q = '{32'h00000008, 32'h00000000, 32'h00000000};
        send_tlp(1'b0);
        repeat (2) @(negedge sys_clk_p);
        n_assert++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pending: m_axis_tvalid=%b required 1 while stalled", m_axis_tvalid);
        end
        #2 sys_reset = 1'b1;
        #1;
        n_assert++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 || s_axis_tready !== 1'b0 ||
            o_mwr_count !== 32'd0 || o_mrd_count !== 32'd0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tvalid=%b tlast=%b tdata=%h tready=%b mwr=%0d mrd=%0d err=%b required all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, o_mwr_count, o_mrd_count, o_err);
        end
        @(negedge sys_clk_p);
        sys_reset = 1'b0;
        mwr_exp = 0;
        mrd_exp = 0;
        err_exp = 0;
        @(negedge sys_clk_p);
        n_assert++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready: s_axis_tready=%b required 1 after release", s_axis_tready);
        end
        do_mrd(32'h10, 10'd2, 1'b0, 16'h0100, 8'h05, 0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_unsupported;
        tx_q = '{32'h30000001, 32'h00000000, 32'h00001000, 32'hDEADBEEF};
        err_exp = 1;
        send_tlp(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk_p);
            n_assert++;
            if (m_axis_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL unsup_cpl: m_axis_tvalid=%b required 0 at cycle %0d", m_axis_tvalid, i);
            end
        end
        n_assert++;
        if (o_err !== 1'b1 || o_mwr_count !== 32'(mwr_exp) || o_mrd_count !== 32'(mrd_exp) || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL unsup_status: err=%b mwr=%0d mrd=%0d tready=%b required 1/%0d/%0d/1",
                     o_err, o_mwr_count, o_mrd_count, s_axis_tready, mwr_exp, mrd_exp);
        end
    endtask

    initial begin
        sys_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_round_trip();
        test_byte_enables();
        test_backpressure();
        test_wrap();
        test_random();
        test_malformed();
        test_reset_mid();
        test_unsupported();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_pcie_host_completer.md
# sim_pcie_host_completer

Simulation-only host memory model on the far side of the simulated PCIe bridge. It consumes the 32-bit AXI-stream TX TLPs that the core sends toward the link and decodes memory writes and memory reads. Writes go into a word-addressed host memory; each read returns a single CplD TLP on an AXI-stream output that feeds the bridge's RX path. It lets the core's D2H writes and DMA reads be checked end to end without a real root complex.

## Interface
- MEM_DEPTH_LOG2, 10, host memory holds 2^N 32-bit words; the word index is addr[N+1:2], modulo depth.
- COMPLETER_ID, 16'h0000, completer ID placed in CplD DW1[31:16].
- sys_clk_p  in  1  clock; every register is clocked on its rising edge.
- sys_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32  TX TLP beat; DW0 is the first beat.
- s_axis_tkeep  in  4  ignored; all beats are treated as full DWs.
- s_axis_tlast  in  1  last beat of the TLP.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid && tready.
- m_axis_tdata  out  32  completion TLP beat.
- m_axis_tlast  out  1  last beat of the completion.
- m_axis_tvalid  out  1  completion beat valid.
- m_axis_tready  in  1  downstream accept.
- o_mwr_count  out  32  count of MWr TLPs fully written.
- o_mrd_count  out  32  count of CplD TLPs fully sent.
- o_err  out  1  sticky: unsupported, malformed, or length-mismatched TLP seen.

## Operation
- DW0 decode: fmt = [30:29], type = [28:24], len = [9:0]; len 0 means 1024 DWs.
- DW1 decode: reqid = [31:16], tag = [15:8], lbe = [7:4], fbe = [3:0].
- Address is DW2 when fmt[0] = 0 (3DW header) and DW3 when fmt[0] = 1 (4DW header); the DW2 upper address of a 4DW header is ignored.
- MWr is fmt 1x with type 00000. Payload word n goes to mem[(idx+n) mod depth]. Byte enables: fbe on word 0; lbe on the last word when len > 1; 4'hF otherwise. BE bit i covers tdata[8i+7:8i].
- MRd is fmt 0x with type 00000. After the tlast beat is accepted, the block emits one CplD and does not split it:
  - DW0 = 32'h4A000000 | len.
  - DW1 = {COMPLETER_ID, 3'b000, 1'b0, bytecount[11:0]}, where bytecount = len*4 truncated to 12 bits (4096 gives 0).
  - DW2 = {reqid, tag, 1'b0, addr[6:2], 2'b00}.
  - Then len data words read from mem[(idx+n) mod depth].
- Any other fmt/type: consume beats through tlast, emit nothing, set o_err.
- tlast before the header is complete, or before len payload words: return to H0 and set o_err. Words already written stay written, and o_mwr_count does not increment.
- Payload beats beyond len before tlast: discarded (DRAIN) and o_err is set. An MWr that reached len still counts.
- States: H0, H1, H2, H3, WDATA, DRAIN, C0, C1, C2, CDATA.
  - H0 → H1 → H2 → (H3 if 4DW).
  - From the last header beat:
    - MWr → WDATA.
    - MRd with tlast → C0.
    - MRd without tlast → DRAIN, set o_err, then C0 after tlast.
    - Unsupported → DRAIN, or H0 if that beat has tlast.
  - C0 → C1 → C2 → CDATA → H0.

## Timing
- Reset values:
  - s_axis_tready = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - Both counters = 0; o_err = 0; state = H0.
  - Memory is not reset.
- s_axis_tready is registered. It is 1 from the first clock edge after reset deassertion in states H0–H3, WDATA and DRAIN, and 0 in states C0–CDATA.
- The MWr write occurs on the accepting edge. A read issued after it observes the data.
- C0 valid: m_axis_tvalid rises on the edge that accepts the MRd tlast beat (or the DRAIN tlast beat).
- Completion beats advance only on tvalid && m_axis_tready. tdata and tlast hold stable while stalled.
- m_axis_tlast is set on the final CDATA beat.
- After the last completion handshake: tvalid = 0 and tready = 1 on that same edge, and state = H0.
- Counters increment on the edge of the final MWr payload handshake or the final CplD handshake. They wrap at 2^32.
- sys_reset asserted mid-TLP or mid-completion clears the outputs immediately (asynchronously). The partial TLP is abandoned.

## Test plan
- Reset then release → all outputs at their reset values; s_axis_tready = 1 one edge after release.
- Round trip:
  - Stimulus: MWr 3DW len 2 at addr 0x10 with data 0xA5A5A5A5, 0x5A5A5A5A; then MRd len 2 at addr 0x10, reqid 0x0100, tag 0x05.
  - Response: CplD beats 0x4A000002, 0x00000008, 0x01000510, 0xA5A5A5A5, 0x5A5A5A5A. tlast is set on the 5th beat only. o_mwr_count = 1, o_mrd_count = 1.
- Byte enables: mem word = 0xFFFFFFFF; MWr len 1, fbe 0x3, data 0x11223344; then MRd len 1 → data 0xFFFF3344.
- Backpressure: hold m_axis_tready low for 3 cycles during CDATA → tdata stable throughout, no beat lost or duplicated; s_axis_tready stays 0 until the completion is done.
- Unsupported TLP (type 10000, 4 beats) → all beats accepted, no completion, o_err = 1, both counters unchanged.
- Wrap: MWr len 2 at the last word (idx = depth-1) → second word lands at index 0. MRd len 0 returns 1024 data words with DW1 bytecount = 0.
